// File: rtl/ysyx_22041211_wbu_if.sv
// Bundle of the EXU handshake, memory read response, register-file write port and
// commit status seen by the write-back unit.
interface ysyx_22041211_wbu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  exu_valid;
  logic                  exu_ready;
  logic [DATA_WIDTH-1:0] exu_result;
  logic [4:0]            exu_rd;
  logic                  exu_reg_wen;
  logic                  exu_mem_ren;
  logic [2:0]            exu_funct3;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            mem_rresp;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [4:0]            rf_rd;
  logic                  rf_wen;
  logic                  wb_done;
  logic                  wb_err;
  logic [31:0]           retire_cnt;

  // Handshake: an instruction transfers on a rising edge where exu_valid and
  // exu_ready are both high; exu_ready is high only while the unit is idle.
  modport slave (
    input  exu_valid, exu_result, exu_rd, exu_reg_wen, exu_mem_ren, exu_funct3,
    input  mem_rvalid, mem_rdata, mem_rresp,
    output exu_ready, rf_wdata, rf_rd, rf_wen, wb_done, wb_err, retire_cnt
  );

  modport master (
    output exu_valid, exu_result, exu_rd, exu_reg_wen, exu_mem_ren, exu_funct3,
    output mem_rvalid, mem_rdata, mem_rresp,
    input  exu_ready, rf_wdata, rf_rd, rf_wen, wb_done, wb_err, retire_cnt
  );
endinterface

// File: rtl/ysyx_22041211_wbu.sv
// Write-back unit: retires one instruction at a time, formats load data and
// drives a one-cycle register-file write pulse with commit/error status.
module ysyx_22041211_wbu #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22041211_wbu_if.slave  wbu_io,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;

  state_e                state_q;
  logic [15:0]           tmo_q;
  logic [4:0]            rd_q;
  logic                  reg_wen_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_q;
  logic                  misalign_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [4:0]            rf_rd_q;
  logic                  rf_wen_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           retire_q;

  logic                  misalign_d;
  logic                  illegal_d;
  logic                  ld_err_d;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data_d;

  always_comb begin
    misalign_d = ((wbu_io.exu_funct3[1:0] == 2'b01) && wbu_io.exu_result[0]) ||
                 ((wbu_io.exu_funct3 == 3'b010) && (wbu_io.exu_result[1:0] != 2'b00));
    illegal_d  = (wbu_io.exu_funct3 == 3'b011) || (wbu_io.exu_funct3 == 3'b110) ||
                 (wbu_io.exu_funct3 == 3'b111);
    ld_err_d   = misalign_q || illegal_q || (wbu_io.mem_rresp != 2'b00);
  end

  always_comb begin
    byte_sel    = 8'h00;
    half_sel    = addr_q[1] ? wbu_io.mem_rdata[31:16] : wbu_io.mem_rdata[15:0];
    load_data_d = wbu_io.mem_rdata;
    case (addr_q)
      2'd0:    byte_sel = wbu_io.mem_rdata[7:0];
      2'd1:    byte_sel = wbu_io.mem_rdata[15:8];
      2'd2:    byte_sel = wbu_io.mem_rdata[23:16];
      default: byte_sel = wbu_io.mem_rdata[31:24];
    endcase
    case (funct3_q)
      3'b000:  load_data_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data_d = {24'h000000, byte_sel};
      3'b001:  load_data_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data_d = {16'h0000, half_sel};
      default: load_data_d = wbu_io.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      rd_q       <= '0;
      reg_wen_q  <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      rf_wdata_q <= '0;
      rf_rd_q    <= '0;
      rf_wen_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      retire_q   <= '0;
    end else begin
      rf_wen_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wbu_io.exu_valid) begin
            rd_q       <= wbu_io.exu_rd;
            reg_wen_q  <= wbu_io.exu_reg_wen;
            funct3_q   <= wbu_io.exu_funct3;
            addr_q     <= wbu_io.exu_result[1:0];
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
            if (wbu_io.exu_mem_ren) begin
              state_q <= WAIT_MEM;
              tmo_q   <= '0;
            end else begin
              state_q    <= WRITE;
              rf_wdata_q <= wbu_io.exu_result;
              rf_rd_q    <= wbu_io.exu_rd;
              rf_wen_q   <= wbu_io.exu_reg_wen && (wbu_io.exu_rd != 5'd0);
              done_q     <= 1'b1;
              retire_q   <= retire_q + 32'd1;
            end
          end
        end
        WAIT_MEM: begin
          tmo_q <= tmo_q + 16'd1;
          // A response on the timeout cycle still completes normally.
          if (wbu_io.mem_rvalid) begin
            state_q    <= WRITE;
            rf_wdata_q <= load_data_d;
            rf_rd_q    <= rd_q;
            rf_wen_q   <= reg_wen_q && (rd_q != 5'd0) && !ld_err_d;
            done_q     <= 1'b1;
            err_q      <= ld_err_d;
            retire_q   <= retire_q + 32'd1;
          end else if (tmo_q == 16'(TIMEOUT - 1)) begin
            state_q  <= WRITE;
            rf_rd_q  <= rd_q;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            retire_q <= retire_q + 32'd1;
          end
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbu_io.exu_ready  = (state_q == IDLE) && !rst;
  assign wbu_io.rf_wdata   = rf_wdata_q;
  assign wbu_io.rf_rd      = rf_rd_q;
  assign wbu_io.rf_wen     = rf_wen_q;
  assign wbu_io.wb_done    = done_q;
  assign wbu_io.wb_err     = err_q;
  assign wbu_io.retire_cnt = retire_q;
  assign state_o           = state_q;

endmodule

// File: doc/ysyx_22041211_wbu.md
Name: ysyx_22041211_wbu

Overview:
Write-back unit between the execute/load-store stages and the register file.
- Accepts one retiring instruction at a time from EXU over a valid/ready handshake.
- For loads, waits for the memory read response, then extracts and sign/zero-extends the loaded value.
- Drives the register-file write port (wdata, rd, regWrite) with a one-cycle write pulse.
- Reports commit, error and a retire count to the rest of the core.

Parameters:
DATA_WIDTH, 32, datapath width (only 32 is supported)
TIMEOUT, 255, WAIT_MEM cycles before a load is aborted (1..65535)

Ports:
clk  in  1  clock (the only clock)
rst  in  1  asynchronous, active-high reset
exu_valid  in  1  EXU presents an instruction
exu_ready  out  1  WBU can accept
exu_result  in  DATA_WIDTH  ALU result / load address
exu_rd  in  5  destination register
exu_reg_wen  in  1  instruction writes rd
exu_mem_ren  in  1  instruction is a load
exu_funct3  in  3  load type
mem_rvalid  in  1  memory read response valid
mem_rdata  in  DATA_WIDTH  aligned 32-bit memory word
mem_rresp  in  2  response code, 0 = OK
rf_wdata  out  DATA_WIDTH  register-file write data
rf_rd  out  5  register-file write address
rf_wen  out  1  register-file write enable (regWrite)
wb_done  out  1  one-cycle commit pulse
wb_err  out  1  one-cycle error pulse, coincident with wb_done
retire_cnt  out  32  number of committed instructions

Behaviour:
- States: IDLE, WAIT_MEM, WRITE. The state is reset asynchronously to IDLE.
- Reset values: all registered outputs are 0; rf_rd is 0; retire_cnt is 0.
- exu_ready = (state == IDLE) && !rst.
  - Accepted instructions are therefore spaced at least 2 cycles apart.
- IDLE, on exu_valid && exu_ready:
  - Capture result, rd, reg_wen, funct3 and addr[1:0] = exu_result[1:0].
  - Compute the misalign flag:
    - LH/LHU with addr[0] = 1.
    - LW with addr[1:0] != 0.
  - Compute the illegal flag: funct3 is 011, 110 or 111.
  - If mem_ren: go to WAIT_MEM and clear the timeout counter.
  - Otherwise: go to WRITE with data = result.
- WAIT_MEM:
  - The counter increments every cycle.
  - On mem_rvalid:
    - data = format(mem_rdata).
    - err = misalign | illegal | (mem_rresp != 0).
    - Go to WRITE.
  - If the counter reaches TIMEOUT-1 without mem_rvalid: err = 1, go to WRITE.
  - mem_rvalid in the same cycle as the timeout takes priority (normal completion).
- Load format rules:
  - LB (000): byte addr[1:0] of the word, sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): half addr[1] of the word, sign-extended.
  - LHU (101): same half, zero-extended.
  - LW (010): the full word.
- WRITE (exactly one cycle):
  - rf_wen = reg_wen && (rd != 0) && !err.
  - rf_wdata = data and rf_rd = rd are stable for the whole cycle.
  - wb_done = 1 and wb_err = err.
  - retire_cnt increments by 1, wrapping from 0xFFFFFFFF to 0.
  - Next state is IDLE.
- Outputs are registered so that rf_wen, rf_wdata and rf_rd are valid for the full WRITE cycle. The register file samples them at the clock edge that ends WRITE.
- Latency:
  - Non-load: accept edge → WRITE in the next cycle (1 cycle).
  - Load: mem_rvalid edge → WRITE in the next cycle.
- rd = 0: rf_wen stays 0, but wb_done still pulses and the retire is counted.
- Errored instructions never write the register file, but are still counted as retired.
- mem_rvalid outside WAIT_MEM is ignored; no state change.
- A non-load instruction ignores mem_* entirely.
- When not in WRITE, rf_wen, wb_done and wb_err are 0. rf_wdata and rf_rd hold their last values.
- Reset asserted in any state:
  - Return to IDLE immediately and clear all outputs and retire_cnt.
  - Any instruction in flight is dropped with no write.
  - A response arriving after reset is ignored.

Test Plan:
- ALU op: exu_result=0x12345678, rd=5, reg_wen=1, mem_ren=0 → next cycle rf_wen=1, rf_rd=5, rf_wdata=0x12345678, wb_done=1, retire_cnt=1.
- LB with addr=0x...3 and mem_rdata=0x80FF7F01 → rf_wdata=0xFFFFFF80. Same with LBU → 0x00000080. LH with addr[1]=1 → 0xFFFF80FF. LHU → 0x000080FF.
- Write to rd=0 with result 0xDEADBEEF → rf_wen stays 0, wb_done=1, retire_cnt increments.
- LW at addr=0x1002, response OK → wb_err=1, rf_wen=0. Separately, a load with mem_rresp=2 → wb_err=1, no write.
- Load with no mem_rvalid for 255 cycles → WRITE with wb_err=1, rf_wen=0. Then back-to-back ALU ops are accepted every 2 cycles, exu_ready=0 in WRITE.
- Assert rst while in WAIT_MEM → immediately exu_ready=0, outputs 0, retire_cnt=0. A later mem_rvalid is ignored, and the first accept after reset release works normally.
